// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the CPU fetch port and its load/store port.
// Data requests win ties. After STARVE_MAX consecutive data grants made while a fetch
// was waiting, the next tie goes to the fetch. The memory sequence has a fixed latency.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                d_req,
  input  logic [DATA_W/8-1:0] d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_valid,
  output logic                busy,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] WAIT_INIT  = 2'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              lat_data;
  logic [BE_W-1:0]   lat_we;
  logic [1:0]        wait_cnt;
  logic [3:0]        starve_cnt;
  logic              grant_d;
  logic              grant_i;
  logic              capture;

  // Next-state decode, grant decision and the strobes that depend only on the current state
  always_comb begin
    next_state = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    capture    = 1'b0;
    busy       = 1'b1;
    mem_en     = 1'b0;
    mem_we     = '0;
    if_valid   = 1'b0;
    d_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (d_req && !(if_req && (starve_cnt == STARVE_LIM))) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_i = 1'b1;
        end
        if (grant_d || grant_i) begin
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en = 1'b1;
        mem_we = lat_we;
        if (lat_data && (lat_we != '0)) begin
          next_state = S_RESP;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 2'd0) begin
          capture    = 1'b1;
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        if_valid   = ~lat_data;
        d_valid    = lat_data;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // State register; reset drops any access that is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latch the winning request at grant, so later changes to the inputs are ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_data  <= 1'b0;
      lat_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_d || grant_i) begin
      lat_data  <= grant_d;
      lat_we    <= grant_d ? d_we : '0;
      mem_addr  <= grant_d ? d_addr : if_addr;
      mem_wdata <= grant_d ? d_wdata : '0;
    end
  end

  // Count consecutive data grants made while a fetch was pending, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Read latency counter, loaded on the issue cycle and run down while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= WAIT_INIT;
    end else if ((state == S_WAIT) && (wait_cnt != 2'd0)) begin
      wait_cnt <= wait_cnt - 2'd1;
    end
  end

  // Capture read data into the port that owns the access; the other port keeps its value
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (capture) begin
      if (lat_data) begin
        d_rdata <= mem_rdata;
      end else begin
        if_rdata <= mem_rdata;
      end
    end
  end

endmodule
